// File: rtl/simple_spi_pkg.sv
// Shared types and helpers for the simple_spi master/slave pair.
// Word width is fixed at 32 bits and the chip-select count at 8.
// Transfer length encoding: 0=8, 1=16, 2=24, 3=32 bits.
package simple_spi_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CS_W   = 8;

  typedef logic [1:0] len_t;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    TRANSFER,
    END
  } m_state_t;

  // Bit count N = 8*(len+1), range 8..32.
  function automatic logic [5:0] len_to_bits(input len_t l);
    return {1'b0, l, 3'b000} + 6'd8;
  endfunction

  // Move an LSB-justified N-bit word so that its first bit sits at bit 31.
  function automatic logic [WORD_W-1:0] left_justify(input logic [WORD_W-1:0] w, input len_t l);
    return w << (6'd32 - len_to_bits(l));
  endfunction

  // Mask selecting the low N bits.
  function automatic logic [WORD_W-1:0] len_mask(input len_t l);
    logic [WORD_W-1:0] ones;
    ones = '1;
    return ones >> (6'd32 - len_to_bits(l));
  endfunction

endpackage

// File: rtl/simple_spi_master_eng.sv
// SPI master engine: generates SCLK and eight active-low chip selects and
// runs full-duplex MSB-first transfers of 8/16/24/32 bits in all CPOL/CPHA
// modes. SCLK half-period H = 2^m_div system clocks.
// Ports: clk/rst (sync, active-low); m_start request; m_busy status;
// m_mosi/m_miso/m_sclk/m_cs serial pins; m_tx_data/m_rx_data words;
// m_chip_addr, m_len, m_div, m_cpol, m_cpha, m_default configuration.
module simple_spi_master_eng
  import simple_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              m_start,
  output logic              m_busy,
  output logic              m_mosi,
  input  logic              m_miso,
  output logic              m_sclk,
  output logic [CS_W-1:0]   m_cs,
  input  logic [WORD_W-1:0] m_tx_data,
  output logic [WORD_W-1:0] m_rx_data,
  input  logic [2:0]        m_chip_addr,
  input  len_t              m_len,
  input  logic [3:0]        m_div,
  input  logic              m_cpol,
  input  logic              m_cpha,
  input  logic              m_default
);

  m_state_t          state, state_nx;
  logic [13:0]       cnt;
  logic [3:0]        div_l;
  len_t              len_l;
  logic [2:0]        addr_l;
  logic              cpol_l, cpha_l;
  logic              sclk_r, mosi_r;
  logic [WORD_W-1:0] tx_sh, rx_sh, tx_lj;
  logic [4:0]        bit_cnt;
  logic [14:0]       h_full;
  logic              tick, lead, trail;

  assign h_full = 15'd1 << div_l;
  assign tick   = ({1'b0, cnt} == h_full - 15'd1);
  assign tx_lj  = left_justify(m_tx_data, m_len);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    lead     = 1'b0;
    trail    = 1'b0;
    case (state)
      IDLE:     if (m_start) state_nx = READY;
      READY:    if (tick) state_nx = TRANSFER;
      TRANSFER: if (tick) begin
        // Leading edge moves SCLK away from CPOL, trailing edge returns it.
        if (sclk_r == cpol_l) begin
          lead = 1'b1;
        end else begin
          trail = 1'b1;
          if (bit_cnt == 5'(len_to_bits(len_l) - 6'd1)) state_nx = END;
        end
      end
      END:      if (tick) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      div_l     <= '0;
      len_l     <= '0;
      addr_l    <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      bit_cnt   <= '0;
      m_rx_data <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (m_start) begin
        div_l   <= m_div;
        len_l   <= m_len;
        addr_l  <= m_chip_addr;
        cpol_l  <= m_cpol;
        cpha_l  <= m_cpha;
        sclk_r  <= m_cpol;
        rx_sh   <= '0;
        bit_cnt <= '0;
        if (!m_cpha) begin
          mosi_r <= tx_lj[WORD_W-1];
          tx_sh  <= tx_lj << 1;
        end else begin
          mosi_r <= m_default;
          tx_sh  <= tx_lj;
        end
      end
    end else begin
      cnt <= tick ? '0 : cnt + 14'd1;
      if (lead || trail) sclk_r <= ~sclk_r;
      if (trail) bit_cnt <= bit_cnt + 5'd1;
      if ((lead && !cpha_l) || (trail && cpha_l)) begin
        rx_sh <= {rx_sh[WORD_W-2:0], m_miso};
      end
      if ((trail && !cpha_l) || (lead && cpha_l)) begin
        mosi_r <= tx_sh[WORD_W-1];
        tx_sh  <= tx_sh << 1;
      end
      // rx_sh started at zero and took exactly N bits, so it is already zero-extended.
      if (state == END && tick) m_rx_data <= rx_sh;
    end
  end

  assign m_busy = (state != IDLE);
  assign m_cs   = (state == IDLE) ? '1 : ~(CS_W'(1) << addr_l);
  assign m_sclk = (state == IDLE) ? m_cpol : sclk_r;
  assign m_mosi = (state == IDLE) ? m_default : mosi_r;

endmodule

// File: rtl/simple_spi_slave_eng.sv
// SPI slave engine: oversamples SCLK/CS/MOSI through 2-flop synchronisers,
// detects SCLK edges in the clk domain and shifts MSB-first in all
// CPOL/CPHA modes. SCLK must be no faster than clk/4.
// Ports: clk/rst (sync, active-low); s_busy status; s_mosi/s_miso/s_sclk/s_cs
// serial pins; s_tx_data/s_rx_data words; s_len, s_cpol, s_cpha, s_default.
module simple_spi_slave_eng
  import simple_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              s_busy,
  input  logic              s_mosi,
  output logic              s_miso,
  input  logic              s_sclk,
  input  logic              s_cs,
  input  logic [WORD_W-1:0] s_tx_data,
  output logic [WORD_W-1:0] s_rx_data,
  input  len_t              s_len,
  input  logic              s_cpol,
  input  logic              s_cpha,
  input  logic              s_default
);

  // [0],[1] synchroniser; [2] previous synchronised value for edge detect.
  logic [2:0]        sclk_q, cs_q;
  logic [1:0]        mosi_q;
  len_t              len_l;
  logic              cpol_l, cpha_l, miso_r;
  logic [WORD_W-1:0] tx_sh, rx_sh, tx_lj;
  logic [5:0]        nbits;
  logic              cs_fall, cs_rise, sclk_edge, lead, trail, sample;

  assign tx_lj     = left_justify(s_tx_data, s_len);
  assign cs_fall   = cs_q[2] & ~cs_q[1];
  assign cs_rise   = ~cs_q[2] & cs_q[1];
  assign sclk_edge = sclk_q[2] ^ sclk_q[1];
  assign lead      = s_busy & sclk_edge & (sclk_q[1] != cpol_l);
  assign trail     = s_busy & sclk_edge & (sclk_q[1] == cpol_l);
  assign sample    = cpha_l ? trail : lead;

  // Outgoing bits are launched as soon as the previous bit has been sampled
  // (first bit on CS fall) instead of on the master's launch edge: with
  // synchroniser latency a launch-edge update would miss the master's next
  // sample at SCLK = clk/4. Launch order and content are unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_q    <= '0;
      cs_q      <= '1;
      mosi_q    <= '0;
      s_busy    <= 1'b0;
      len_l     <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      miso_r    <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      nbits     <= '0;
      s_rx_data <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], s_sclk};
      cs_q   <= {cs_q[1:0], s_cs};
      mosi_q <= {mosi_q[0], s_mosi};
      if (cs_fall) begin
        s_busy <= 1'b1;
        len_l  <= s_len;
        cpol_l <= s_cpol;
        cpha_l <= s_cpha;
        miso_r <= tx_lj[WORD_W-1];
        tx_sh  <= tx_lj << 1;
        rx_sh  <= '0;
        nbits  <= '0;
      end else if (cs_rise) begin
        s_busy <= 1'b0;
        if (s_busy && nbits >= len_to_bits(len_l)) s_rx_data <= rx_sh & len_mask(len_l);
      end else if (sample) begin
        rx_sh  <= {rx_sh[WORD_W-2:0], mosi_q[1]};
        miso_r <= tx_sh[WORD_W-1];
        tx_sh  <= tx_sh << 1;
        if (nbits != 6'h3F) nbits <= nbits + 6'd1;
      end
    end
  end

  assign s_miso = s_busy ? miso_r : s_default;

endmodule

// File: rtl/simple_spi.sv
// simple_spi: independent SPI master and slave engines sharing one clock and
// reset. No internal wiring between them; MOSI/MISO/SCLK/CS are connected
// externally. Ports: m_* master interface, s_* slave interface, clk/rst shared.
module simple_spi
  import simple_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              m_start,
  output logic              m_busy,
  output logic              m_mosi,
  input  logic              m_miso,
  output logic              m_sclk,
  output logic [CS_W-1:0]   m_cs,
  input  logic [WORD_W-1:0] m_tx_data,
  output logic [WORD_W-1:0] m_rx_data,
  input  logic [2:0]        m_chip_addr,
  input  len_t              m_len,
  input  logic [3:0]        m_div,
  input  logic              m_cpol,
  input  logic              m_cpha,
  input  logic              m_default,
  output logic              s_busy,
  input  logic              s_mosi,
  output logic              s_miso,
  input  logic              s_sclk,
  input  logic              s_cs,
  input  logic [WORD_W-1:0] s_tx_data,
  output logic [WORD_W-1:0] s_rx_data,
  input  len_t              s_len,
  input  logic              s_cpol,
  input  logic              s_cpha,
  input  logic              s_default
);

  simple_spi_master_eng u_master (
    .clk        (clk),
    .rst        (rst),
    .m_start    (m_start),
    .m_busy     (m_busy),
    .m_mosi     (m_mosi),
    .m_miso     (m_miso),
    .m_sclk     (m_sclk),
    .m_cs       (m_cs),
    .m_tx_data  (m_tx_data),
    .m_rx_data  (m_rx_data),
    .m_chip_addr(m_chip_addr),
    .m_len      (m_len),
    .m_div      (m_div),
    .m_cpol     (m_cpol),
    .m_cpha     (m_cpha),
    .m_default  (m_default)
  );

  simple_spi_slave_eng u_slave (
    .clk       (clk),
    .rst       (rst),
    .s_busy    (s_busy),
    .s_mosi    (s_mosi),
    .s_miso    (s_miso),
    .s_sclk    (s_sclk),
    .s_cs      (s_cs),
    .s_tx_data (s_tx_data),
    .s_rx_data (s_rx_data),
    .s_len     (s_len),
    .s_cpol    (s_cpol),
    .s_cpha    (s_cpha),
    .s_default (s_default)
  );

endmodule

// File: tb/tb_simple_spi.sv
// Loopback bench: master pins wired to the slave, m_cs[0] selects the slave.
module tb_simple_spi;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_start, m_busy, m_mosi, m_miso, m_sclk;
  logic [7:0]  m_cs;
  logic [31:0] m_tx_data, m_rx_data;
  logic [2:0]  m_chip_addr;
  logic [1:0]  m_len;
  logic [3:0]  m_div;
  logic        m_cpol, m_cpha, m_default;
  logic        s_busy, s_mosi, s_miso, s_sclk, s_cs;
  logic [31:0] s_tx_data, s_rx_data;
  logic [1:0]  s_len;
  logic        s_cpol, s_cpha, s_default;

  always #5 clk = ~clk;

  simple_spi dut (
    .clk(clk), .rst(rst),
    .m_start(m_start), .m_busy(m_busy), .m_mosi(m_mosi), .m_miso(m_miso),
    .m_sclk(m_sclk), .m_cs(m_cs), .m_tx_data(m_tx_data), .m_rx_data(m_rx_data),
    .m_chip_addr(m_chip_addr), .m_len(m_len), .m_div(m_div),
    .m_cpol(m_cpol), .m_cpha(m_cpha), .m_default(m_default),
    .s_busy(s_busy), .s_mosi(s_mosi), .s_miso(s_miso), .s_sclk(s_sclk),
    .s_cs(s_cs), .s_tx_data(s_tx_data), .s_rx_data(s_rx_data),
    .s_len(s_len), .s_cpol(s_cpol), .s_cpha(s_cpha), .s_default(s_default)
  );

  assign s_mosi = m_mosi;
  assign s_sclk = m_sclk;
  assign s_cs   = m_cs[0];
  assign m_miso = s_miso;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: the exchanged word is the other side's tx truncated to N bits.
  function automatic logic [31:0] model_rx(input logic [31:0] tx, input logic [1:0] len);
    longint unsigned n;
    n = 64'(8 * (int'(len) + 1));
    return 32'(64'(tx) % (64'd1 << n));
  endfunction

  function automatic int unsigned model_busy(input logic [1:0] len, input logic [3:0] div);
    return (2 * 8 * (int'(len) + 1) + 2) * (1 << div);
  endfunction

  task automatic xfer(input logic [31:0] mtx, input logic [31:0] stx, input logic [1:0] len,
                      input logic cpol, input logic cpha, input logic [3:0] div, input logic [2:0] addr,
                      output logic [31:0] mrx, output logic [31:0] srx,
                      output int unsigned busy_cyc, output logic [7:0] cs_seen,
                      output int unsigned sbusy_cyc);
    @(negedge clk);
    m_tx_data = mtx; s_tx_data = stx; m_len = len; s_len = len;
    m_cpol = cpol; s_cpol = cpol; m_cpha = cpha; s_cpha = cpha;
    m_div = div; m_chip_addr = addr;
    repeat (4) @(negedge clk);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    busy_cyc = 0; sbusy_cyc = 0; cs_seen = m_cs;
    while (m_busy && busy_cyc < 20000) begin
      busy_cyc++;
      if (s_busy) sbusy_cyc++;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    mrx = m_rx_data;
    srx = s_rx_data;
  endtask

  typedef struct {
    logic [31:0] mtx, stx;
    logic [1:0]  len;
    logic        cpol, cpha;
    logic [3:0]  div;
    logic [31:0] exp_mrx, exp_srx;
    int unsigned exp_busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] mrx, srx, last_srx, rmtx, rstx;
    logic [7:0]  cs_seen;
    int unsigned bcyc, sbcyc, extra, cyc;
    logic [1:0]  rlen;
    logic [3:0]  rdiv;
    logic        rpol, rpha;

    tbl[0]  = '{32'h000000AA, 32'h000000FB, 2'd0, 1'b0, 1'b0, 4'd1, 32'h000000FB, 32'h000000AA, 36};
    tbl[1]  = '{32'hC926A05C, 32'hF97632D4, 2'd3, 1'b0, 1'b0, 4'd1, 32'hF97632D4, 32'hC926A05C, 132};
    tbl[2]  = '{32'h0000ACD9, 32'h00005D6A, 2'd1, 1'b0, 1'b0, 4'd1, 32'h00005D6A, 32'h0000ACD9, 68};
    tbl[3]  = '{32'h123456AA, 32'hABCDEFFB, 2'd0, 1'b0, 1'b0, 4'd1, 32'h000000FB, 32'h000000AA, 36};
    tbl[4]  = '{32'h000000AA, 32'h000000FB, 2'd0, 1'b0, 1'b1, 4'd1, 32'h000000FB, 32'h000000AA, 36};
    tbl[5]  = '{32'h000000AA, 32'h000000FB, 2'd0, 1'b1, 1'b0, 4'd1, 32'h000000FB, 32'h000000AA, 36};
    tbl[6]  = '{32'h000000AA, 32'h000000FB, 2'd0, 1'b1, 1'b1, 4'd1, 32'h000000FB, 32'h000000AA, 36};
    tbl[7]  = '{32'h000000AA, 32'h000000FB, 2'd0, 1'b0, 1'b0, 4'd3, 32'h000000FB, 32'h000000AA, 144};
    tbl[8]  = '{32'h000000AA, 32'h000000FB, 2'd0, 1'b0, 1'b1, 4'd3, 32'h000000FB, 32'h000000AA, 144};
    tbl[9]  = '{32'h000000AA, 32'h000000FB, 2'd0, 1'b1, 1'b0, 4'd3, 32'h000000FB, 32'h000000AA, 144};
    tbl[10] = '{32'h000000AA, 32'h000000FB, 2'd0, 1'b1, 1'b1, 4'd3, 32'h000000FB, 32'h000000AA, 144};
    tbl[11] = '{32'h00A5C31E, 32'h007E8142, 2'd2, 1'b1, 1'b1, 4'd2, 32'h007E8142, 32'h00A5C31E, 200};

    // Reset state, with non-zero idle levels so they are visible.
    rst = 1'b0; m_start = 1'b0; m_tx_data = '0; s_tx_data = '0;
    m_len = '0; s_len = '0; m_div = 4'd1; m_chip_addr = '0;
    m_cpol = 1'b1; s_cpol = 1'b1; m_cpha = 1'b0; s_cpha = 1'b0;
    m_default = 1'b1; s_default = 1'b1;
    repeat (3) @(negedge clk);
    check("reset m_busy", 32'(m_busy), 32'd0);
    check("reset m_cs", 32'(m_cs), 32'hFF);
    check("reset m_sclk", 32'(m_sclk), 32'd1);
    check("reset m_mosi", 32'(m_mosi), 32'd1);
    check("reset m_rx", m_rx_data, 32'd0);
    check("reset s_busy", 32'(s_busy), 32'd0);
    check("reset s_miso", 32'(s_miso), 32'd1);
    check("reset s_rx", s_rx_data, 32'd0);
    m_cpol = 1'b0; s_cpol = 1'b0; m_default = 1'b0; s_default = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Reset in the middle of a 32-bit transfer.
    m_tx_data = 32'hDEADBEEF; s_tx_data = 32'h01234567; m_len = 2'd3; s_len = 2'd3;
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    repeat (20) @(negedge clk);
    check("midxfer m_busy", 32'(m_busy), 32'd1);
    check("midxfer m_cs", 32'(m_cs), 32'hFE);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort m_busy", 32'(m_busy), 32'd0);
    check("abort m_cs", 32'(m_cs), 32'hFF);
    repeat (8) @(negedge clk);
    check("abort m_rx", m_rx_data, 32'd0);
    check("abort s_rx", s_rx_data, 32'd0);
    check("abort s_busy", 32'(s_busy), 32'd0);
    last_srx = 32'd0;

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].mtx, tbl[i].stx, tbl[i].len, tbl[i].cpol, tbl[i].cpha, tbl[i].div, 3'd0,
           mrx, srx, bcyc, cs_seen, sbcyc);
      check($sformatf("tbl%0d m_rx", i), mrx, tbl[i].exp_mrx);
      check($sformatf("tbl%0d s_rx", i), srx, tbl[i].exp_srx);
      check($sformatf("tbl%0d busy_cycles", i), bcyc, tbl[i].exp_busy);
      check($sformatf("tbl%0d m_cs", i), 32'(cs_seen), 32'hFE);
      check($sformatf("tbl%0d sclk_idle", i), 32'(m_sclk), 32'(tbl[i].cpol));
      last_srx = tbl[i].exp_srx;
    end

    // Start pulsed while busy: ignored, exactly one transfer.
    @(negedge clk);
    m_tx_data = 32'h3C; s_tx_data = 32'h81; m_len = 2'd0; s_len = 2'd0;
    m_cpol = 1'b0; s_cpol = 1'b0; m_cpha = 1'b0; s_cpha = 1'b0; m_div = 4'd1;
    repeat (4) @(negedge clk);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    cyc = 0;
    while (m_busy && cyc < 20000) begin
      if (cyc == 10) begin m_start = 1'b1; m_tx_data = 32'h55; m_len = 2'd3; end
      if (cyc == 11) m_start = 1'b0;
      cyc++;
      @(negedge clk);
    end
    m_start = 1'b0;
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (m_busy) extra++;
    end
    check("busystart busy_cycles", cyc, 32'd36);
    check("busystart no_retrigger", extra, 32'd0);
    check("busystart m_rx", m_rx_data, 32'h81);
    check("busystart s_rx", s_rx_data, 32'h3C);
    last_srx = 32'h3C;

    // Chip address 5: slave on m_cs[0] must stay deselected.
    s_default = 1'b1; m_default = 1'b1;
    xfer(32'h5A, 32'h00, 2'd0, 1'b0, 1'b0, 4'd1, 3'd5, mrx, srx, bcyc, cs_seen, sbcyc);
    check("addr5 m_cs", 32'(cs_seen), 32'hDF);
    check("addr5 s_busy_cycles", sbcyc, 32'd0);
    check("addr5 s_rx", srx, last_srx);
    check("addr5 m_rx", mrx, 32'hFF);
    check("addr5 busy_cycles", bcyc, 32'd36);
    check("addr5 s_miso idle", 32'(s_miso), 32'd1);
    check("addr5 m_mosi idle", 32'(m_mosi), 32'd1);

    // Randomised transfers against the model.
    for (int i = 0; i < 12; i++) begin
      rmtx = $urandom; rstx = $urandom;
      rlen = 2'($urandom_range(0, 3));
      rpol = 1'($urandom_range(0, 1)); rpha = 1'($urandom_range(0, 1));
      rdiv = 4'($urandom_range(1, 2));
      m_default = 1'($urandom_range(0, 1)); s_default = 1'($urandom_range(0, 1));
      xfer(rmtx, rstx, rlen, rpol, rpha, rdiv, 3'd0, mrx, srx, bcyc, cs_seen, sbcyc);
      check($sformatf("rnd%0d m_rx", i), mrx, model_rx(rstx, rlen));
      check($sformatf("rnd%0d s_rx", i), srx, model_rx(rmtx, rlen));
      check($sformatf("rnd%0d busy_cycles", i), bcyc, model_busy(rlen, rdiv));
      check($sformatf("rnd%0d m_mosi idle", i), 32'(m_mosi), 32'(m_default));
      check($sformatf("rnd%0d s_miso idle", i), 32'(s_miso), 32'(s_default));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simple_spi.md
Name: simple_spi

Overview:
- Parameter-free SPI pair: a master engine and a slave engine, both in one system clock domain.
- The master generates SCLK and eight active-low chip selects. It runs full-duplex transfers of 8/16/24/32 bits, MSB first, in all four CPOL/CPHA modes.
- The slave oversamples SCLK/CS/MOSI with the system clock.
- The two engines share no internal wiring. MOSI/MISO/SCLK/CS are connected at the board or bench level.

Parameters:
- none. Word width is fixed at 32 bits and the chip-select count at 8.

Ports:
- clk  in  1  system clock, shared by both engines.
- rst  in  1  reset for both engines; one clock, synchronous, active-low.
- m_start  in  1  master: request a transfer. Sampled only while idle.
- m_busy  out  1  master: transfer in progress.
- m_mosi  out  1  master serial data out.
- m_miso  in  1  master serial data in.
- m_sclk  out  1  master serial clock.
- m_cs  out  8  master chip selects, active-low.
- m_tx_data  in  32  master transmit word, LSB-justified.
- m_rx_data  out  32  master received word, LSB-justified, zero-extended.
- m_chip_addr  in  3  index of the m_cs bit to assert.
- m_len  in  2  transfer length: 0=8, 1=16, 2=24, 3=32 bits.
- m_div  in  4  SCLK half-period H = 2^m_div clocks; legal range 1..14.
- m_cpol, m_cpha  in  1 each  master SPI mode.
- m_default  in  1  master idle level of m_mosi.
- s_busy  out  1  slave: selected and transferring.
- s_mosi  in  1  slave serial data in.
- s_miso  out  1  slave serial data out.
- s_sclk  in  1  slave serial clock.
- s_cs  in  1  slave chip select, active-low.
- s_tx_data  in  32  slave transmit word, LSB-justified.
- s_rx_data  out  32  slave received word, LSB-justified.
- s_len  in  2  slave transfer length, same encoding as m_len.
- s_cpol, s_cpha  in  1 each  slave SPI mode.
- s_default  in  1  slave idle level of s_miso.

Behaviour:
- Reset (rst=0 at a clk edge) applies to both engines:
  - m_busy=0, m_cs=8'hFF, m_sclk=m_cpol, m_mosi=m_default, m_rx_data=0.
  - s_busy=0, s_miso=s_default, s_rx_data=0.
  - Any transfer in progress is aborted with no rx update.
- Bit count N = 8*(m_len+1). Bit k of a transfer carries tx_data[N-1-k].
- Master FSM (2-bit state): IDLE -> READY -> TRANSFER -> END -> IDLE.
  - IDLE: if m_start=1, latch tx_data, len, chip_addr, div, cpol, cpha. Next clk: m_busy=1, m_cs[addr]=0 (all other bits 1), go READY.
  - READY: wait H clocks. If CPHA=0, drive the first bit on m_mosi at CS assertion.
  - TRANSFER: toggle m_sclk every H clocks, 2N edges total; a 5-bit counter counts bits.
    - CPHA=0: sample m_miso on leading (odd) edges; shift out on trailing edges.
    - CPHA=1: shift out on leading edges; sample on trailing edges.
  - END: hold H clocks with m_sclk at CPOL, then raise all m_cs, load m_rx_data, set m_busy=0 and m_mosi=m_default, go IDLE.
  - m_busy is high for exactly (2N+2)*H clocks.
  - m_start while busy is ignored. A start held high re-triggers only after returning to IDLE. Input changes mid-transfer have no effect.
- Slave:
  - s_sclk, s_cs and s_mosi pass through 2-flop synchronisers; SCLK edges are detected in the clk domain. SCLK must be no faster than clk/4.
  - On the synchronised s_cs falling edge: s_busy=1, latch s_tx_data/s_len/s_cpol/s_cpha. If CPHA=0, drive the first bit on s_miso immediately.
  - Sample/shift edges follow the same CPHA rule as the master.
  - On the synchronised s_cs rising edge: s_busy=0, s_miso=s_default.
    - If at least N bits were sampled, s_rx_data = the last N bits, zero-extended.
    - Otherwise s_rx_data is unchanged.
  - SCLK edges while s_cs is high are ignored. Bits sampled beyond N keep shifting; only the last N are kept.

Decomposition:
- Shared package simple_spi_pkg holds:
  - len_t (2-bit) and a len_to_bits function.
  - The master state enum {IDLE, READY, TRANSFER, END}.
  - Constants WORD_W=32 and CS_W=8.
- Two natural sub-modules, simple_spi_master_eng and simple_spi_slave_eng. The top only wires them to the ports.

Test Plan:
- Setup for the first three scenarios: master wired to slave, m_cs[0] -> s_cs, mode 0, m_div=1, defaults 0.
- 8-bit transfer: m_tx=0xAA, s_tx=0xFB, len=0 -> m_rx=0x000000FB, s_rx=0x000000AA, m_busy high 36 clocks, m_cs=8'hFE during the transfer.
- 32-bit transfer: m_tx=0xC926A05C, s_tx=0xF97632D4, len=3 -> m_rx=0xF97632D4, s_rx=0xC926A05C.
- 16-bit transfer: m_tx=0xACD9, s_tx=0x5D6A, len=1 -> m_rx=0x00005D6A, s_rx=0x0000ACD9.
- All four CPOL/CPHA modes, m_div in {1,3}, repeat the 8-bit case -> identical results; m_sclk idles at CPOL.
- Reset mid-transfer, and m_start pulsed while busy:
  - Reset -> m_cs=0xFF, m_busy=0, rx words unchanged from 0.
  - Start while busy -> ignored, no second transfer.
- m_chip_addr=5 -> m_cs=8'hDF. The slave on m_cs[0] stays idle, s_miso=s_default, s_rx unchanged.
